keypad_scan_4x4: RTL and testbench

//  Input-side counterpart to the switch/7-segment display path: scans a 4x4 matrix keypad,

---
 rtl/keypad_pkg.sv | 38 +++
 rtl/keypad_scan_4x4_sync.sv | 27 ++
 rtl/keypad_scan_4x4.sv | 178 +++++++++++++++++
 tb/tb_keypad_scan_4x4.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM states,
// the idle row-drive pattern and the row/column to hex-code key map.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN      = 2'd0,
        DEB_PRESS = 2'd1,
        PRESSED   = 2'd2,
        DEB_REL   = 2'd3
    } state_t;

    localparam logic [3:0] ROW_RESET = 4'b1110;

    // Row 3 carries the '*' and '#' keys, reported as E and F.
    function automatic logic [3:0] key_map(input logic [1:0] rowIdx, input logic [1:0] colIdx);
        logic [3:0] code;
        case ({rowIdx, colIdx})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = 4'hA;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hC;
            4'b11_00: code = 4'hE;
            4'b11_01: code = 4'h0;
            4'b11_10: code = 4'hF;
            default:  code = 4'hD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/keypad_scan_4x4_sync.sv
// Two-flop synchronizer; resets to all-ones so an idle, pulled-up bus
// never looks like a key press coming out of reset.
module sync_2ff #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '1;
            r_sync <= '1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/keypad_scan_4x4.sv
// 4x4 matrix keypad scanner: rotates an active-low row strobe, debounces a
// single-key press/release per dwell tick and emits one hex code per press.
module keypad_scan_4x4
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_TICKS = 20
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    output logic [3:0] ROW,
    input  logic [3:0] COL,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

    logic [3:0]       w_colS;
    logic [DIV_W-1:0] r_div;
    logic             w_tick;
    logic [3:0]       r_row;
    state_t           r_state, w_nextState;
    logic [CNT_W-1:0] r_cnt, w_nextCnt;
    logic [1:0]       r_keyRow, w_nextKeyRow;
    logic [1:0]       r_keyCol, w_nextKeyCol;
    logic [3:0]       r_keyCode;
    logic             r_keyValid;
    logic             r_keyHeld;
    logic             w_single;
    logic [1:0]       w_colIdx;
    logic [1:0]       w_rowIdx;
    logic             w_rotate;
    logic             w_accept;
    logic             w_release;

    sync_2ff #(.WIDTH(4)) u_colSync (
        .clk   (CLOCK_50),
        .rst_n (RESET_N),
        .i_d   (COL),
        .o_q   (w_colS)
    );

    // Row changes only happen on a tick, so wrapping here also restarts the dwell.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N)
            r_div <= '0;
        else if (w_tick)
            r_div <= '0;
        else if (r_div != DIV_LAST)
            r_div <= r_div + DIV_W'(1);
    end

    assign w_tick = (r_div == DIV_LAST);

    always_comb begin
        w_single = 1'b1;
        w_colIdx = 2'd0;
        case (w_colS)
            4'b1110: w_colIdx = 2'd0;
            4'b1101: w_colIdx = 2'd1;
            4'b1011: w_colIdx = 2'd2;
            4'b0111: w_colIdx = 2'd3;
            default: w_single = 1'b0;
        endcase
    end

    always_comb begin
        w_rowIdx = 2'd0;
        case (r_row)
            4'b1101: w_rowIdx = 2'd1;
            4'b1011: w_rowIdx = 2'd2;
            4'b0111: w_rowIdx = 2'd3;
            default: w_rowIdx = 2'd0;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state  <= SCAN;
            r_cnt    <= '0;
            r_keyRow <= 2'd0;
            r_keyCol <= 2'd0;
        end else begin
            r_state  <= w_nextState;
            r_cnt    <= w_nextCnt;
            r_keyRow <= w_nextKeyRow;
            r_keyCol <= w_nextKeyCol;
        end
    end

    // Counters only advance while below the terminal count, so they can never wrap.
    always_comb begin
        w_nextState  = r_state;
        w_nextCnt    = r_cnt;
        w_nextKeyRow = r_keyRow;
        w_nextKeyCol = r_keyCol;
        w_rotate     = 1'b0;
        w_accept     = 1'b0;
        w_release    = 1'b0;
        if (w_tick) begin
            case (r_state)
                SCAN: begin
                    if (w_single) begin
                        w_nextKeyRow = w_rowIdx;
                        w_nextKeyCol = w_colIdx;
                        w_nextCnt    = '0;
                        w_nextState  = DEB_PRESS;
                    end else begin
                        w_rotate = 1'b1;
                    end
                end
                DEB_PRESS: begin
                    if (w_single && (w_colIdx == r_keyCol)) begin
                        if (r_cnt >= CNT_LAST) begin
                            w_accept    = 1'b1;
                            w_nextState = PRESSED;
                        end else begin
                            w_nextCnt = r_cnt + CNT_W'(1);
                        end
                    end else begin
                        w_nextState = SCAN;
                        w_rotate    = 1'b1;
                    end
                end
                PRESSED: begin
                    if (w_colS == 4'hF) begin
                        w_nextCnt   = '0;
                        w_nextState = DEB_REL;
                    end
                end
                DEB_REL: begin
                    if (w_colS == 4'hF) begin
                        if (r_cnt >= CNT_LAST) begin
                            w_release   = 1'b1;
                            w_rotate    = 1'b1;
                            w_nextState = SCAN;
                        end else begin
                            w_nextCnt = r_cnt + CNT_W'(1);
                        end
                    end else begin
                        w_nextState = PRESSED;
                    end
                end
                default: w_nextState = SCAN;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_row      <= ROW_RESET;
            r_keyCode  <= 4'h0;
            r_keyValid <= 1'b0;
            r_keyHeld  <= 1'b0;
        end else begin
            r_keyValid <= w_accept;
            if (w_rotate)
                r_row <= {r_row[2:0], r_row[3]};
            if (w_accept) begin
                r_keyCode <= key_map(r_keyRow, r_keyCol);
                r_keyHeld <= 1'b1;
            end else if (w_release) begin
                r_keyHeld <= 1'b0;
            end
        end
    end

    assign ROW       = r_row;
    assign key_code  = r_keyCode;
    assign key_valid = r_keyValid;
    assign key_held  = r_keyHeld;

endmodule

// File: tb/tb_keypad_scan_4x4.sv
// Directed bench for keypad_scan_4x4 (SCAN_DIV=8, DEBOUNCE_TICKS=3) with a
// behavioural keypad that pulls COL[c] low while ROW[r] is low for each held key.
module tb_keypad_scan_4x4;

    logic        clock;
    logic        resetN;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  keyCode;
    logic        keyValid;
    logic        keyHeld;
    logic [15:0] keys;

    int          checkCount;
    int          errorCount;
    int          validCount;
    int          validBase;
    logic [3:0]  lastCode;

    keypad_scan_4x4 #(
        .SCAN_DIV       (8),
        .DEBOUNCE_TICKS (3)
    ) dut (
        .CLOCK_50  (clock),
        .RESET_N   (resetN),
        .ROW       (row),
        .COL       (col),
        .key_code  (keyCode),
        .key_valid (keyValid),
        .key_held  (keyHeld)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always_comb begin
        col = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !row[r])
                    col[c] = 1'b0;
    end

    always @(negedge clock) begin
        if (keyValid === 1'b1) begin
            validCount = validCount + 1;
            lastCode   = keyCode;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount = checkCount + 1;
        if (observed !== expected) begin
            errorCount = errorCount + 1;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic [15:0] mask);
        keys = mask;
    endtask

    task automatic waitRow(input string tag, input logic [3:0] target, input int maxCycles);
        logic found;
        found = 1'b0;
        for (int i = 0; i < maxCycles; i++) begin
            if (row === target) begin
                found = 1'b1;
                break;
            end
            cycles(1);
        end
        checkOutput(tag, {31'b0, found}, 32'd1);
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        validCount = 0;
        lastCode   = 4'h0;
        keys       = 16'h0;
        resetN     = 1'b0;

        // Reset values, then the idle scan stepping every 8 cycles
        cycles(3);
        checkOutput("rstRow",   {28'b0, row},     32'hE);
        checkOutput("rstCode",  {28'b0, keyCode}, 32'h0);
        checkOutput("rstValid", {31'b0, keyValid}, 32'd0);
        checkOutput("rstHeld",  {31'b0, keyHeld},  32'd0);
        resetN = 1'b1;
        cycles(7);
        checkOutput("scanRow0End", {28'b0, row}, 32'hE);
        cycles(1);
        checkOutput("scanRow1", {28'b0, row}, 32'hD);
        cycles(8);
        checkOutput("scanRow2", {28'b0, row}, 32'hB);
        cycles(8);
        checkOutput("scanRow3", {28'b0, row}, 32'h7);
        cycles(8);
        checkOutput("scanWrap", {28'b0, row}, 32'hE);

        // Clean press of '6': row 0 just began its dwell, so timing is exact
        applyStimulus(16'h0040);
        cycles(39);
        checkOutput("p6ValidEarly", {31'b0, keyValid}, 32'd0);
        cycles(1);
        checkOutput("p6Valid", {31'b0, keyValid}, 32'd1);
        checkOutput("p6Code",  {28'b0, keyCode},  32'h6);
        cycles(1);
        checkOutput("p6ValidOneCycle", {31'b0, keyValid}, 32'd0);
        checkOutput("p6Count", validCount, 32'd1);
        cycles(39);
        checkOutput("p6Held",    {31'b0, keyHeld}, 32'd1);
        checkOutput("p6RowHold", {28'b0, row},     32'hD);
        applyStimulus(16'h0);
        cycles(31);
        checkOutput("p6HeldLate", {31'b0, keyHeld}, 32'd1);
        cycles(1);
        checkOutput("p6Released",  {31'b0, keyHeld}, 32'd0);
        checkOutput("p6RowResume", {28'b0, row},     32'hB);
        checkOutput("p6CountAfter", validCount, 32'd1);

        // Bouncing '9', then held steady
        validBase = validCount;
        for (int i = 0; i < 32; i++) begin
            applyStimulus(((i / 5) % 2 == 0) ? 16'h0400 : 16'h0000);
            cycles(1);
        end
        checkOutput("b9NoPulse", validCount - validBase, 32'd0);
        applyStimulus(16'h0400);
        cycles(80);
        checkOutput("b9Pulse", validCount - validBase, 32'd1);
        checkOutput("b9Code",  {28'b0, lastCode}, 32'h9);
        checkOutput("b9Held",  {31'b0, keyHeld},  32'd1);
        applyStimulus(16'h0);
        cycles(48);
        checkOutput("b9Released", {31'b0, keyHeld}, 32'd0);

        // Ghost: '1' and '2' together on row 0
        validBase = validCount;
        applyStimulus(16'h0003);
        cycles(48);
        checkOutput("ghostNoPulse", validCount - validBase, 32'd0);
        checkOutput("ghostNoHeld",  {31'b0, keyHeld}, 32'd0);
        waitRow("ghostRow0", 4'hE, 40);
        waitRow("ghostRow1", 4'hD, 10);
        applyStimulus(16'h0001);
        cycles(80);
        checkOutput("ghostPulse", validCount - validBase, 32'd1);
        checkOutput("ghostCode",  {28'b0, lastCode}, 32'h1);
        applyStimulus(16'h0);
        cycles(48);
        checkOutput("ghostReleased", {31'b0, keyHeld}, 32'd0);

        // Release glitch on '#'
        validBase = validCount;
        applyStimulus(16'h4000);
        cycles(80);
        checkOutput("hashPulse", validCount - validBase, 32'd1);
        checkOutput("hashCode",  {28'b0, lastCode}, 32'hF);
        applyStimulus(16'h0);
        cycles(12);
        applyStimulus(16'h4000);
        cycles(8);
        checkOutput("hashGlitchHeld", {31'b0, keyHeld}, 32'd1);
        applyStimulus(16'h0);
        cycles(54);
        checkOutput("hashReleased",   {31'b0, keyHeld}, 32'd0);
        checkOutput("hashSinglePulse", validCount - validBase, 32'd1);
        checkOutput("hashCodeKept",   {28'b0, keyCode}, 32'hF);

        // Async reset in DEB_PRESS and in PRESSED with '5' held
        validBase = validCount;
        waitRow("rstWaitRow0", 4'hE, 40);
        applyStimulus(16'h0020);
        waitRow("rstWaitRow1", 4'hD, 10);
        cycles(12);
        checkOutput("debRowHold", {28'b0, row}, 32'hD);
        checkOutput("debNoPulse", validCount - validBase, 32'd0);
        resetN = 1'b0;
        #1;
        checkOutput("debRstRow",   {28'b0, row},      32'hE);
        checkOutput("debRstCode",  {28'b0, keyCode},  32'h0);
        checkOutput("debRstValid", {31'b0, keyValid}, 32'd0);
        checkOutput("debRstHeld",  {31'b0, keyHeld},  32'd0);
        cycles(3);
        resetN = 1'b1;
        cycles(80);
        checkOutput("rst1Pulse", validCount - validBase, 32'd1);
        checkOutput("rst1Code",  {28'b0, keyCode}, 32'h5);
        checkOutput("rst1Held",  {31'b0, keyHeld}, 32'd1);
        resetN = 1'b0;
        #1;
        checkOutput("prsRstHeld", {31'b0, keyHeld}, 32'd0);
        checkOutput("prsRstCode", {28'b0, keyCode}, 32'h0);
        checkOutput("prsRstRow",  {28'b0, row},     32'hE);
        cycles(3);
        checkOutput("prsRstNoPulse", validCount - validBase, 32'd1);
        resetN = 1'b1;
        cycles(80);
        checkOutput("rst2Pulse", validCount - validBase, 32'd2);
        checkOutput("rst2Code",  {28'b0, keyCode}, 32'h5);
        checkOutput("rst2Held",  {31'b0, keyHeld}, 32'd1);
        applyStimulus(16'h0);
        cycles(48);
        checkOutput("rst2Released", {31'b0, keyHeld}, 32'd0);
        checkOutput("rst2NoExtra",  validCount - validBase, 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
